// File: rtl/hazard3_dport_arbiter.sv
// rtl/hazard3_dport_arbiter.sv - N-way AHB5 data-port arbiter with fixed-priority or round-robin grant
module hazard3_dport_arbiter #(
    parameter int               N_SRC       = 2,
    parameter int               W_ADDR      = 32,
    parameter int               W_DATA      = 32,
    parameter bit               ROUND_ROBIN = 1'b0,
    parameter logic [N_SRC-1:0] PIPE_MASK   = {N_SRC{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC-1:0]          src_aph_req,
    input  logic [N_SRC-1:0]          src_aph_excl,
    input  logic [N_SRC*W_ADDR-1:0]   src_haddr,
    input  logic [N_SRC-1:0]          src_hwrite,
    input  logic [N_SRC*3-1:0]        src_hsize,
    input  logic [N_SRC-1:0]          src_priv,
    input  logic [N_SRC*W_DATA-1:0]   src_wdata,
    output logic [N_SRC-1:0]          src_aph_ready,
    output logic [N_SRC-1:0]          src_dph_ready,
    output logic [N_SRC-1:0]          src_dph_err,
    output logic [N_SRC-1:0]          src_dph_exokay,
    output logic [W_DATA-1:0]         src_rdata,
    output logic [W_ADDR-1:0]         haddr,
    output logic                      hwrite,
    output logic [1:0]                htrans,
    output logic [2:0]                hsize,
    output logic [2:0]                hburst,
    output logic [3:0]                hprot,
    output logic                      hmastlock,
    output logic [7:0]                hmaster,
    output logic                      hexcl,
    input  logic                      hready,
    input  logic                      hresp,
    input  logic                      hexokay,
    output logic [W_DATA-1:0]         hwdata,
    input  logic [W_DATA-1:0]         hrdata
);

    localparam int W_PTR = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic             hold_aph_q, hold_aph_d;
    logic [N_SRC-1:0] gnt_prev_q;
    logic [N_SRC-1:0] dph_active_q, dph_active_d;
    logic [W_PTR-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] gnt;
    logic [W_PTR-1:0] gnt_idx;
    logic             aph_priv;

    assign eligible = src_aph_req & (PIPE_MASK | ~dph_active_q);

    // Rank each eligible source by its distance from the priority origin
    // (index 0 for fixed priority, rr_ptr for round-robin); the nearest wins.
    always_comb begin
        int sel;
        int best;
        int rel;
        sel  = -1;
        best = N_SRC;
        rel  = 0;
        gnt  = '0;
        if (hold_aph_q) begin
            gnt = gnt_prev_q;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                rel = ROUND_ROBIN ? (i - int'(rr_ptr_q)) : i;
                if (rel < 0) rel = rel + N_SRC;
                if (eligible[i] && rel < best) begin
                    best = rel;
                    sel  = i;
                end
            end
            for (int i = 0; i < N_SRC; i++) gnt[i] = (sel == i);
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) gnt_idx = W_PTR'(i);
        end
    end

    // With no grant the bus shows source 0's fields under an IDLE transfer.
    always_comb begin
        haddr    = src_haddr[W_ADDR-1:0];
        hwrite   = src_hwrite[0];
        hsize    = src_hsize[2:0];
        aph_priv = src_priv[0];
        hexcl    = src_aph_excl[0];
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                haddr    = src_haddr[i*W_ADDR +: W_ADDR];
                hwrite   = src_hwrite[i];
                hsize    = src_hsize[i*3 +: 3];
                aph_priv = src_priv[i];
                hexcl    = src_aph_excl[i];
            end
        end
    end

    always_comb begin
        hwdata = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (dph_active_q[i]) hwdata = src_wdata[i*W_DATA +: W_DATA];
        end
    end

    assign htrans    = (|gnt) ? 2'b10 : 2'b00;
    assign hburst    = 3'b000;
    assign hmastlock = 1'b0;
    assign hprot     = {2'b00, aph_priv, 1'b1};
    assign hmaster   = 8'(gnt_idx);
    assign src_rdata = hrdata;

    assign src_aph_ready  = {N_SRC{hready}}  & gnt;
    assign src_dph_ready  = {N_SRC{hready}}  & dph_active_q;
    assign src_dph_err    = {N_SRC{hresp}}   & dph_active_q;
    assign src_dph_exokay = {N_SRC{hexokay}} & dph_active_q;

    // An error response drops the hold so the stalled address phase can be
    // re-arbitrated (AHB cancel) rather than forced through.
    assign hold_aph_d   = (|gnt) && !hready && !hresp;
    assign dph_active_d = hready ? gnt : dph_active_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hready && (|gnt)) begin
            rr_ptr_d = (gnt_idx == W_PTR'(N_SRC - 1)) ? '0 : gnt_idx + W_PTR'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_aph_q   <= 1'b0;
            gnt_prev_q   <= '0;
            dph_active_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            hold_aph_q   <= hold_aph_d;
            gnt_prev_q   <= gnt;
            dph_active_q <= dph_active_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_hazard3_dport_arbiter.sv
// tb/tb_hazard3_dport_arbiter.sv - scoreboard bench for hazard3_dport_arbiter (fixed-priority and round-robin)
module tb_hazard3_dport_arbiter;

    typedef struct {
        int          m;
        logic [31:0] a;
        logic        w;
        logic [2:0]  sz;
        logic [3:0]  prot;
        logic        ex;
    } aph_t;

    typedef struct {
        int          s;
        logic        err;
        logic        exok;
        logic [31:0] wd;
    } dph_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, rr_req, excl, hwr, priv;
    logic [95:0] addr, wdata;
    logic [8:0]  size;
    logic        hready, hresp, hexokay;
    logic [31:0] hrdata;

    logic [2:0]  f_aph_rdy, f_dph_rdy, f_dph_err, f_exok;
    logic [31:0] f_rdata, f_haddr, f_hwdata;
    logic        f_hwrite, f_hmastlock, f_hexcl;
    logic [1:0]  f_htrans;
    logic [2:0]  f_hsize, f_hburst;
    logic [3:0]  f_hprot;
    logic [7:0]  f_hmaster;

    logic [2:0]  r_aph_rdy, r_dph_rdy, r_dph_err, r_exok;
    logic [31:0] r_rdata, r_haddr, r_hwdata;
    logic        r_hwrite, r_hmastlock, r_hexcl;
    logic [1:0]  r_htrans;
    logic [2:0]  r_hsize, r_hburst;
    logic [3:0]  r_hprot;
    logic [7:0]  r_hmaster;

    int   total = 0;
    int   bad   = 0;
    aph_t fq[$];
    aph_t rq[$];
    dph_t dq[$];
    aph_t ea;
    dph_t ed;
    logic stall_prev;
    int   stall_m;

    always #5 clk = ~clk;

    hazard3_dport_arbiter #(.N_SRC(3), .W_ADDR(32), .W_DATA(32), .ROUND_ROBIN(1'b0), .PIPE_MASK(3'b101)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .src_aph_req(req), .src_aph_excl(excl), .src_haddr(addr), .src_hwrite(hwr),
        .src_hsize(size), .src_priv(priv), .src_wdata(wdata),
        .src_aph_ready(f_aph_rdy), .src_dph_ready(f_dph_rdy), .src_dph_err(f_dph_err),
        .src_dph_exokay(f_exok), .src_rdata(f_rdata),
        .haddr(f_haddr), .hwrite(f_hwrite), .htrans(f_htrans), .hsize(f_hsize), .hburst(f_hburst),
        .hprot(f_hprot), .hmastlock(f_hmastlock), .hmaster(f_hmaster), .hexcl(f_hexcl),
        .hready(hready), .hresp(hresp), .hexokay(hexokay), .hwdata(f_hwdata), .hrdata(hrdata)
    );

    hazard3_dport_arbiter #(.N_SRC(3), .W_ADDR(32), .W_DATA(32), .ROUND_ROBIN(1'b1), .PIPE_MASK(3'b111)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .src_aph_req(rr_req), .src_aph_excl(excl), .src_haddr(addr), .src_hwrite(hwr),
        .src_hsize(size), .src_priv(priv), .src_wdata(wdata),
        .src_aph_ready(r_aph_rdy), .src_dph_ready(r_dph_rdy), .src_dph_err(r_dph_err),
        .src_dph_exokay(r_exok), .src_rdata(r_rdata),
        .haddr(r_haddr), .hwrite(r_hwrite), .htrans(r_htrans), .hsize(r_hsize), .hburst(r_hburst),
        .hprot(r_hprot), .hmastlock(r_hmastlock), .hmaster(r_hmaster), .hexcl(r_hexcl),
        .hready(hready), .hresp(hresp), .hexokay(hexokay), .hwdata(r_hwdata), .hrdata(hrdata)
    );

    function automatic aph_t mk_aph(int s);
        aph_t t;
        t.m = s;
        case (s)
            0:       begin t.a = 32'h1000_0000; t.w = 1'b0; t.sz = 3'd0; t.prot = 4'b0011; t.ex = 1'b0; end
            1:       begin t.a = 32'h2000_0000; t.w = 1'b1; t.sz = 3'd1; t.prot = 4'b0001; t.ex = 1'b0; end
            default: begin t.a = 32'h3000_0000; t.w = 1'b0; t.sz = 3'd2; t.prot = 4'b0001; t.ex = 1'b1; end
        endcase
        return t;
    endfunction

    function automatic logic [31:0] src_wd(int s);
        case (s)
            0:       return 32'h1111_1111;
            1:       return 32'hDEAD_BEEF;
            default: return 32'h2222_2222;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int s, input logic err, input logic exok);
        dph_t d;
        fq.push_back(mk_aph(s));
        d.s = s; d.err = err; d.exok = exok; d.wd = src_wd(s);
        dq.push_back(d);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (f_htrans[1] && hready) begin
                if (fq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL fp_aph_unexpected act=%0d exp=none", f_hmaster);
                end else begin
                    ea = fq.pop_front();
                    check("fp_hmaster", 64'(f_hmaster), 64'(ea.m));
                    check("fp_haddr",   64'(f_haddr),   64'(ea.a));
                    check("fp_hwrite",  64'(f_hwrite),  64'(ea.w));
                    check("fp_hsize",   64'(f_hsize),   64'(ea.sz));
                    check("fp_hprot",   64'(f_hprot),   64'(ea.prot));
                    check("fp_hexcl",   64'(f_hexcl),   64'(ea.ex));
                end
            end
            if (r_htrans[1] && hready) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rr_aph_unexpected act=%0d exp=none", r_hmaster);
                end else begin
                    ea = rq.pop_front();
                    check("rr_hmaster", 64'(r_hmaster), 64'(ea.m));
                    check("rr_haddr",   64'(r_haddr),   64'(ea.a));
                end
            end
            if (|f_dph_rdy) begin
                if (dq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL fp_dph_unexpected act=%0b exp=none", f_dph_rdy);
                end else begin
                    ed = dq.pop_front();
                    check("fp_dph_ready", 64'(f_dph_rdy), 64'(3'b001 << ed.s));
                    check("fp_dph_err",   64'(f_dph_err), ed.err  ? 64'(3'b001 << ed.s) : 64'd0);
                    check("fp_dph_exok",  64'(f_exok),    ed.exok ? 64'(3'b001 << ed.s) : 64'd0);
                    check("fp_hwdata",    64'(f_hwdata),  64'(ed.wd));
                    check("fp_rdata",     64'(f_rdata),   64'(hrdata));
                end
            end
            if (stall_prev) check("no_withdraw", 64'(req[stall_m]), 64'd1);
            stall_prev = f_htrans[1] && !hready && !hresp;
            stall_m    = int'(f_hmaster);
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; rr_req = '0;
        addr  = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        wdata = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        size  = {3'd2, 3'd1, 3'd0};
        hwr = 3'b010; priv = 3'b001; excl = 3'b100;
        hready = 1'b1; hresp = 1'b0; hexokay = 1'b0; hrdata = 32'hCAFE_0000;
        stall_prev = 1'b0; stall_m = 0;
        cyc(); cyc();
        check("rst_htrans",    64'(f_htrans),    64'd0);
        check("rst_dph_ready", 64'(f_dph_rdy),   64'd0);
        check("rst_hwdata",    64'(f_hwdata),    64'd0);
        check("rst_hmaster",   64'(f_hmaster),   64'd0);
        check("rst_hburst",    64'(f_hburst),    64'd0);
        check("rst_hmastlock", 64'(f_hmastlock), 64'd0);
        rst_n = 1'b1;

        // fixed priority: 0 beats 2, then 2 next cycle
        req = 3'b101; issue(0, 1'b0, 1'b1);
        #2 check("t1_aph_ready", 64'(f_aph_rdy), 64'b001);
        cyc();
        req = 3'b100; hexokay = 1'b1; issue(2, 1'b0, 1'b0); cyc();
        req = 3'b000; hexokay = 1'b0; cyc();

        // round-robin rotation 0,1,2,0,1,2
        rr_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            rq.push_back(mk_aph(k % 3));
            cyc();
        end
        rr_req = 3'b000; cyc();

        // wait-state hold on src 1 while src 0 arrives
        req = 3'b010; hready = 1'b0;
        #2 check("t3_aph_rdy_c0", 64'(f_aph_rdy), 64'd0); check("t3_haddr_c0", 64'(f_haddr), 64'h2000_0000);
        cyc();
        req = 3'b011;
        #2 check("t3_aph_rdy_c1", 64'(f_aph_rdy), 64'd0); check("t3_haddr_c1", 64'(f_haddr), 64'h2000_0000);
        cyc();
        #2 check("t3_aph_rdy_c2", 64'(f_aph_rdy), 64'd0); check("t3_haddr_c2", 64'(f_haddr), 64'h2000_0000);
        cyc();
        hready = 1'b1; issue(1, 1'b0, 1'b0);
        #2 check("t3_aph_rdy_c3", 64'(f_aph_rdy), 64'b010);
        cyc();
        req = 3'b001; issue(0, 1'b0, 1'b0); cyc();
        req = 3'b000; cyc();

        // error response cancels src 0's stalled address phase
        req = 3'b010; issue(1, 1'b1, 1'b0); cyc();
        req = 3'b001; hready = 1'b0; hresp = 1'b1;
        #2 check("t4_err_c1", 64'(f_dph_err), 64'b010); check("t4_dph_rdy_c1", 64'(f_dph_rdy), 64'd0);
        cyc();
        hready = 1'b1; issue(0, 1'b0, 1'b0);
        #2 check("t4_regrant", 64'(f_aph_rdy), 64'b001);
        cyc();
        req = 3'b000; hresp = 1'b0; cyc();

        // src 1 may not pipeline behind its own data phase
        req = 3'b010; issue(1, 1'b0, 1'b0); cyc();
        hready = 1'b0;
        #2 check("t5_blocked_c1", 64'(f_htrans), 64'd0); check("t5_hwdata", 64'(f_hwdata), 64'hDEAD_BEEF);
        cyc();
        hready = 1'b1;
        #2 check("t5_blocked_c2", 64'(f_htrans), 64'd0);
        cyc();
        issue(1, 1'b0, 1'b0);
        #2 check("t5_regrant", 64'(f_aph_rdy), 64'b010);
        cyc();
        req = 3'b000; cyc();

        // asynchronous reset with a held aph, live data phase and moved rr_ptr
        req = 3'b100; rr_req = 3'b001;
        fq.push_back(mk_aph(2)); rq.push_back(mk_aph(0));
        cyc();
        req = 3'b001; rr_req = 3'b000; hready = 1'b0; cyc();
        #1 rst_n = 1'b0; hready = 1'b1;
        #1 check("t6_dph_rdy", 64'(f_dph_rdy), 64'd0); check("t6_hwdata", 64'(f_hwdata), 64'd0);
        check("t6_htrans_follow", 64'(f_htrans), 64'b10);
        req = 3'b100; rr_req = 3'b111;
        #1 check("t6_hold_clr", 64'(f_hmaster), 64'd2); check("t6_rrptr_clr", 64'(r_hmaster), 64'd0);
        check("t6_rr_dph_rdy", 64'(r_dph_rdy), 64'd0);
        cyc();
        req = 3'b000; rr_req = 3'b000; rst_n = 1'b1;
        cyc(); cyc();

        check("fq_empty", 64'(fq.size()), 64'd0);
        check("rq_empty", 64'(rq.size()), 64'd0);
        check("dq_empty", 64'(dq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
